fsm_convert_float_to_fixed: RTL
===============================

FSM_CONVERT_FLOAT_TO_FIXED -- requirements
Module: fsm_convert_float_to_fixed

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock; all state updates occur on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port BEGIN_FSM, input, 1 bit: conversion request, sampled in IDLE and in DONE.
REQ-004 SHALL have port ACK_FSM, input, 1 bit: consumer acknowledge of the result, honoured only in DONE.
REQ-005 SHALL have port Exp_out, input, 1 bit: registered datapath flag "exponent > 127", valid one cycle after the float register loads.
REQ-006 SHALL have port Exp, input, 8 bits: biased exponent of the stored float.
REQ-007 SHALL have port EN_REG1, output, 1 bit: load enable for the float register.
REQ-008 SHALL have port LOAD, output, 1 bit: barrel-shifter load.
REQ-009 SHALL have port MS_1, output, 1 bit: 1 selects the computed shift amount, 0 forces shift 0.
REQ-010 SHALL have port EN_REG2, output, 1 bit: load enable for the fixed-point result register.
REQ-011 SHALL have port RDY, output, 1 bit: result valid in the fixed register.
REQ-012 SHALL have port OVF, output, 1 bit: the result overflowed the 32-bit fixed format.

Function
REQ-013 SHALL be a Moore FSM; all outputs SHALL be registered and decoded from state or registered flags only.
REQ-014 SHALL implement the states IDLE, LOAD_FLOAT, WAIT_CMP, LOAD_SHIFT, WAIT_SHIFT, LOAD_FIXED and DONE.
REQ-015 In IDLE, BEGIN_FSM=1 SHALL move the FSM to LOAD_FLOAT; otherwise it SHALL stay in IDLE.
REQ-016 The FSM SHALL move unconditionally LOAD_FLOAT->WAIT_CMP->LOAD_SHIFT->WAIT_SHIFT->LOAD_FIXED->DONE, one cycle per state.
REQ-017 EN_REG1 SHALL be 1 only in LOAD_FLOAT, LOAD only in LOAD_SHIFT, and EN_REG2 only in LOAD_FIXED; each SHALL be a single-cycle pulse.
REQ-018 MS_1 SHALL be latched on entry to LOAD_SHIFT as (Exp != 8'd127), held through LOAD_FIXED, and cleared in IDLE.
REQ-019 OVF SHALL be latched on entry to LOAD_SHIFT as Exp_out AND (Exp > 8'd132), i.e. a left shift of more than 5 places; it SHALL hold until the next LOAD_FLOAT clears it.
REQ-020 RDY SHALL be 1 only in DONE; with BEGIN_FSM sampled high at edge N, RDY SHALL rise at edge N+6.
REQ-021 In DONE, ACK_FSM=1 with BEGIN_FSM=0 SHALL return the FSM to IDLE.
REQ-022 In DONE, ACK_FSM=1 with BEGIN_FSM=1 SHALL move the FSM directly to LOAD_FLOAT (back-to-back conversion).
REQ-023 BEGIN_FSM outside IDLE and DONE SHALL be ignored and SHALL NOT be queued.
REQ-024 ACK_FSM outside DONE SHALL be ignored.
REQ-025 In DONE without ACK_FSM, the FSM SHALL hold RDY=1 indefinitely.
REQ-026 Any unreachable state encoding SHALL recover to IDLE on the next edge with all enables at 0.

Reset
REQ-027 RST=0 SHALL immediately force state IDLE and EN_REG1=EN_REG2=LOAD=MS_1=RDY=OVF=0, regardless of CLK.
REQ-028 Reset asserted mid-conversion SHALL abort the conversion; no enable pulse SHALL occur while RST=0.
REQ-029 After RST deasserts, the first possible EN_REG1 pulse SHALL occur one edge after BEGIN_FSM is sampled high.

Structure
REQ-030 The state enum, the constant BIAS=8'd127 and the constant MAX_LSHIFT=5 SHALL reside in a shared package.
REQ-031 Exponent classification (MS_1 and OVF next values) SHALL be one sub-module, exp_classifier, which is combinational and instantiated once.
REQ-032 The block SHALL contain no datapath arithmetic beyond 8-bit compares.

Verification
REQ-033 Float 0x3F800000 (1.0), BEGIN pulse at edge 0 -> EN_REG1 at 1, LOAD at 3, EN_REG2 at 5, RDY at 6, MS_1=0, OVF=0.
REQ-034 Float 0x40800000 (4.0, Exp=129) -> MS_1=1, Exp_out=1, OVF=0; float 0x3F000000 (0.5, Exp=126) -> MS_1=1, Exp_out=0, OVF=0.
REQ-035 Float 0x42000000 (Exp=132) -> OVF=0; float 0x42800000 (Exp=133) -> OVF=1, which clears at the next LOAD_FLOAT.
REQ-036 RDY held with ACK=0 for 10 cycles -> state stays DONE; ACK=1 with BEGIN=1 -> EN_REG1 on the next edge; BEGIN pulsed during WAIT_SHIFT -> ignored.
REQ-037 RST driven low in WAIT_CMP, asynchronously between edges -> all outputs 0 immediately; no LOAD or EN_REG2 pulse until a new BEGIN.

Source files
------------

// File: rtl/fsm_convert_float_to_fixed_pkg.sv
// Shared types and constants for the float-to-fixed conversion controller.
package fsm_convert_float_to_fixed_pkg;

    localparam int unsigned EXP_W = 8;

    localparam logic [EXP_W-1:0] BIAS       = 8'd127;
    localparam logic [EXP_W-1:0] MAX_LSHIFT = 8'd5;
    // Largest exponent whose left shift still fits the 32-bit fixed format
    localparam logic [EXP_W-1:0] OVF_EXP    = BIAS + MAX_LSHIFT;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_FLOAT = 3'd1,
        WAIT_CMP   = 3'd2,
        LOAD_SHIFT = 3'd3,
        WAIT_SHIFT = 3'd4,
        LOAD_FIXED = 3'd5,
        DONE       = 3'd6
    } state_t;

endpackage

// File: rtl/exp_classifier.sv
// Combinational exponent classification: shift-enable and overflow next values.
module exp_classifier
    import fsm_convert_float_to_fixed_pkg::*;
(
    input  logic [EXP_W-1:0] exp_val,
    input  logic             exp_gt_bias,
    output logic             ms_1_c,
    output logic             ovf_c
);

    assign ms_1_c = (exp_val != BIAS);
    assign ovf_c  = exp_gt_bias && (exp_val > OVF_EXP);

endmodule

// File: rtl/fsm_convert_float_to_fixed.sv
// Moore controller sequencing float load, shift and fixed-point result capture.
module fsm_convert_float_to_fixed
    import fsm_convert_float_to_fixed_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             BEGIN_FSM,
    input  logic             ACK_FSM,
    input  logic             Exp_out,
    input  logic [EXP_W-1:0] Exp,
    output logic             EN_REG1,
    output logic             LOAD,
    output logic             MS_1,
    output logic             EN_REG2,
    output logic             RDY,
    output logic             OVF
);

    state_t state;
    logic   ms_1_c;
    logic   ovf_c;

    exp_classifier u_exp_classifier (
        .exp_val     (Exp),
        .exp_gt_bias (Exp_out),
        .ms_1_c      (ms_1_c),
        .ovf_c       (ovf_c)
    );

    // Outputs are registered decodes of the current state, so they trail it by one edge
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            EN_REG1 <= 1'b0;
            LOAD    <= 1'b0;
            MS_1    <= 1'b0;
            EN_REG2 <= 1'b0;
            RDY     <= 1'b0;
            OVF     <= 1'b0;
        end else begin
            EN_REG1 <= (state == LOAD_FLOAT);
            LOAD    <= (state == LOAD_SHIFT);
            EN_REG2 <= (state == LOAD_FIXED);
            RDY     <= (state == DONE);
            case (state)
                IDLE: begin
                    MS_1 <= 1'b0;
                    if (BEGIN_FSM) begin
                        state <= LOAD_FLOAT;
                    end
                end
                LOAD_FLOAT: begin
                    OVF   <= 1'b0;
                    state <= WAIT_CMP;
                end
                WAIT_CMP: begin
                    state <= LOAD_SHIFT;
                end
                LOAD_SHIFT: begin
                    MS_1  <= ms_1_c;
                    OVF   <= ovf_c;
                    state <= WAIT_SHIFT;
                end
                WAIT_SHIFT: begin
                    state <= LOAD_FIXED;
                end
                LOAD_FIXED: begin
                    state <= DONE;
                end
                DONE: begin
                    // Acknowledge with a pending request chains straight into the next load
                    if (ACK_FSM) begin
                        state <= BEGIN_FSM ? LOAD_FLOAT : IDLE;
                    end
                end
                default: begin
                    MS_1  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
